// File: rtl/tspi_rx_if.sv
// Tri-SPI receiver bus: serial input lanes, latch strobe, decoded pixel writes and line status.
// The master drives the serial stream; the slave is the receiver.
interface tspi_rx_if;
  logic [2:0] sdi;
  logic       sdv;
  logic       lat;
  logic       pix_we;
  logic [5:0] pix_row;
  logic [2:0] pix_col;
  logic [2:0] pix_val;
  logic       frame_done;
  logic [5:0] grid_num;
  logic       grid_err;
  logic       lane_err;
  logic       len_err;

  modport master (
    output sdi, sdv, lat,
    input  pix_we, pix_row, pix_col, pix_val, frame_done, grid_num, grid_err, lane_err, len_err
  );

  modport slave (
    input  sdi, sdv, lat,
    output pix_we, pix_row, pix_col, pix_val, frame_done, grid_num, grid_err, lane_err, len_err
  );
endinterface

// File: rtl/tspi_rx.sv
// Tri-SPI line receiver: deserialises 288-bit lines (234 pixel bits + 54 grid bits),
// emits one pixel write per pixel bit and reports grid pair and protocol errors on each latch.
module tspi_rx (
  input  logic       clk,
  input  logic       rst_n,
  tspi_rx_if.slave   bus
);

  localparam logic [8:0] LineBits = 9'd288;
  localparam logic [8:0] LastPix  = 9'd233;
  localparam logic [8:0] LastGrid = 9'd287;
  localparam logic [8:0] GridBase = 9'd234;
  localparam logic [5:0] MaxFirst = 6'd51;

  typedef enum logic [1:0] {StIdle, StPixel, StGrid, StFull} state_e;

  state_e     state_q, state_d, state_b;

  logic       lat_q;
  logic       lat_edge;
  logic [8:0] bcnt_q, bcnt_d, bcnt_b;
  logic [5:0] row_q, row_d, row_b;
  logic [2:0] mod_q, mod_d, mod_b;
  logic [5:0] first_q, first_d, first_b;
  logic [1:0] ones_q, ones_d, ones_b;
  logic       adj_q, adj_d, adj_b;
  logic       lane_q, lane_d, lane_b;
  logic       ovr_q, ovr_d, ovr_b;

  logic       take_pix, take_grid, take_over;
  logic [2:0] col_map;
  logic [5:0] grid_k;
  logic       lane_mis;

  logic       pix_we_q, pix_we_d;
  logic [5:0] pix_row_q, pix_row_d;
  logic [2:0] pix_col_q, pix_col_d;
  logic [2:0] pix_val_q, pix_val_d;

  // Line status is captured on the latch edge and published one cycle later.
  logic       pend_q;
  logic [5:0] snap_num_q;
  logic       snap_gerr_q, snap_lane_q, snap_len_q;
  logic       close_valid;
  logic [5:0] close_num;
  logic       close_len;

  logic       frame_done_q;
  logic [5:0] grid_num_q;
  logic       grid_err_q, lane_err_q, len_err_q;

  assign lat_edge = bus.lat & ~lat_q;
  assign state_b  = lat_edge ? StIdle : state_q;

  // Line state as seen by this cycle's bit: a latch edge starts it from scratch.
  always_comb begin
    if (lat_edge) begin
      bcnt_b  = '0;
      row_b   = '0;
      mod_b   = '0;
      first_b = '0;
      ones_b  = '0;
      adj_b   = 1'b0;
      lane_b  = 1'b0;
      ovr_b   = 1'b0;
    end else begin
      bcnt_b  = bcnt_q;
      row_b   = row_q;
      mod_b   = mod_q;
      first_b = first_q;
      ones_b  = ones_q;
      adj_b   = adj_q;
      lane_b  = lane_q;
      ovr_b   = ovr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_b;
    if (bus.sdv) begin
      case (state_b)
        StIdle:  state_d = StPixel;
        StPixel: if (bcnt_b == LastPix) state_d = StGrid;
        StGrid:  if (bcnt_b == LastGrid) state_d = StFull;
        StFull:  state_d = StFull;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    take_pix  = bus.sdv & ((state_b == StIdle) | (state_b == StPixel));
    take_grid = bus.sdv & (state_b == StGrid);
    take_over = bus.sdv & (state_b == StFull);
    // Pixels arrive A, F, B, E, C, D within each group.
    case (mod_b)
      3'd0:    col_map = 3'd0;
      3'd1:    col_map = 3'd5;
      3'd2:    col_map = 3'd1;
      3'd3:    col_map = 3'd4;
      3'd4:    col_map = 3'd2;
      3'd5:    col_map = 3'd3;
      default: col_map = 3'd0;
    endcase
  end

  assign grid_k   = 6'(bcnt_b - GridBase);
  assign lane_mis = (bus.sdi[0] != bus.sdi[1]) | (bus.sdi[1] != bus.sdi[2]);

  always_comb begin
    bcnt_d    = bcnt_b;
    row_d     = row_b;
    mod_d     = mod_b;
    first_d   = first_b;
    ones_d    = ones_b;
    adj_d     = adj_b;
    lane_d    = lane_b;
    ovr_d     = ovr_b;
    pix_we_d  = 1'b0;
    pix_row_d = pix_row_q;
    pix_col_d = pix_col_q;
    pix_val_d = pix_val_q;

    if (take_pix) begin
      pix_we_d  = 1'b1;
      pix_row_d = row_b;
      pix_col_d = col_map;
      pix_val_d = bus.sdi;
      if (mod_b == 3'd5) begin
        mod_d = '0;
        row_d = row_b + 6'd1;
      end else begin
        mod_d = mod_b + 3'd1;
      end
    end

    if (take_grid) begin
      if (lane_mis) lane_d = 1'b1;
      if (bus.sdi[0]) begin
        case (ones_b)
          2'd0: begin
            first_d = grid_k;
            ones_d  = 2'd1;
          end
          2'd1: begin
            adj_d  = (grid_k == first_b + 6'd1);
            ones_d = 2'd2;
          end
          default: ones_d = 2'd3;
        endcase
      end
    end

    if (take_over) ovr_d = 1'b1;
    if (take_pix | take_grid) bcnt_d = bcnt_b + 9'd1;
  end

  always_comb begin
    close_valid = (ones_q == 2'd2) & adj_q & (first_q <= MaxFirst);
    close_num   = close_valid ? first_q + 6'd1 : 6'd0;
    close_len   = (bcnt_q != LineBits) | ovr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q        <= 1'b0;
      bcnt_q       <= '0;
      row_q        <= '0;
      mod_q        <= '0;
      first_q      <= '0;
      ones_q       <= '0;
      adj_q        <= 1'b0;
      lane_q       <= 1'b0;
      ovr_q        <= 1'b0;
      pix_we_q     <= 1'b0;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
      pix_val_q    <= '0;
      pend_q       <= 1'b0;
      snap_num_q   <= '0;
      snap_gerr_q  <= 1'b0;
      snap_lane_q  <= 1'b0;
      snap_len_q   <= 1'b0;
      frame_done_q <= 1'b0;
      grid_num_q   <= '0;
      grid_err_q   <= 1'b0;
      lane_err_q   <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      lat_q     <= bus.lat;
      bcnt_q    <= bcnt_d;
      row_q     <= row_d;
      mod_q     <= mod_d;
      first_q   <= first_d;
      ones_q    <= ones_d;
      adj_q     <= adj_d;
      lane_q    <= lane_d;
      ovr_q     <= ovr_d;
      pix_we_q  <= pix_we_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
      pix_val_q <= pix_val_d;
      pend_q    <= lat_edge;
      if (lat_edge) begin
        snap_num_q  <= close_num;
        snap_gerr_q <= ~close_valid;
        snap_lane_q <= lane_q;
        snap_len_q  <= close_len;
      end
      frame_done_q <= pend_q;
      if (pend_q) begin
        grid_num_q <= snap_num_q;
        grid_err_q <= snap_gerr_q;
        lane_err_q <= snap_lane_q;
        len_err_q  <= snap_len_q;
      end
    end
  end

  assign bus.pix_we     = pix_we_q;
  assign bus.pix_row    = pix_row_q;
  assign bus.pix_col    = pix_col_q;
  assign bus.pix_val    = pix_val_q;
  assign bus.frame_done = frame_done_q;
  assign bus.grid_num   = grid_num_q;
  assign bus.grid_err   = grid_err_q;
  assign bus.lane_err   = lane_err_q;
  assign bus.len_err    = len_err_q;

endmodule

// File: tb/tb_tspi_rx.sv
// Directed bench for tspi_rx: table of whole-line vectors plus hand sequences for
// reset, pixel decode, grid sweep, latch/bit coincidence and mid-line reset.
module tb_tspi_rx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tspi_rx_if bus ();

  tspi_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          nbits;
    logic [53:0] gmask;
    int          bad_k;
    int          exp_num;
    int          exp_gerr;
    int          exp_lane;
    int          exp_len;
    int          exp_we;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int we_total = 0;
  int fd_total = 0;
  logic [5:0] log_row [512];
  logic [2:0] log_col [512];
  logic [2:0] log_val [512];
  int colmap [6] = '{0, 5, 1, 4, 2, 3};
  vec_t vecs [11];

  always @(negedge clk) begin
    if (bus.pix_we) begin
      log_row[we_total % 512] <= bus.pix_row;
      log_col[we_total % 512] <= bus.pix_col;
      log_val[we_total % 512] <= bus.pix_val;
      we_total <= we_total + 1;
    end
    if (bus.frame_done) fd_total <= fd_total + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [53:0] gm(input int k);
    gm = 54'd1 << k;
  endfunction

  function automatic vec_t mkv(input int n, input logic [53:0] m, input int bk, input int num,
                               input int gerr, input int lane, input int len, input int we);
    vec_t v;
    v.nbits = n; v.gmask = m; v.bad_k = bk; v.exp_num = num;
    v.exp_gerr = gerr; v.exp_lane = lane; v.exp_len = len; v.exp_we = we;
    return v;
  endfunction

  task automatic step(input logic [2:0] s, input logic v, input logic l);
    bus.sdi = s;
    bus.sdv = v;
    bus.lat = l;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int start, input int n, input logic [53:0] m, input int bk);
    logic [2:0] s;
    for (int i = start; i < start + n; i++) begin
      if (i < 234) begin
        s = 3'(i % 8);
      end else if (i < 288) begin
        s = m[i - 234] ? 3'b111 : 3'b000;
        if (i - 234 == bk) s = 3'b101;
      end else begin
        s = 3'b000;
      end
      step(s, 1'b1, 1'b0);
    end
  endtask

  // LAT held two cycles: FRAME_DONE must pulse once, one cycle after the edge is seen.
  task automatic close_line(input string nm);
    step(3'b000, 1'b0, 1'b1);
    chk({nm, "_fd_early"}, int'(bus.frame_done), 0);
    step(3'b000, 1'b0, 1'b1);
    chk({nm, "_fd_pulse"}, int'(bus.frame_done), 1);
    step(3'b000, 1'b0, 1'b0);
    chk({nm, "_fd_once"}, int'(bus.frame_done), 0);
  endtask

  task automatic chk_status(input string nm, input int num, input int gerr, input int lane,
                            input int len);
    chk({nm, "_grid_num"}, int'(bus.grid_num), num);
    chk({nm, "_grid_err"}, int'(bus.grid_err), gerr);
    chk({nm, "_lane_err"}, int'(bus.lane_err), lane);
    chk({nm, "_len_err"}, int'(bus.len_err), len);
  endtask

  initial begin
    int base_we;
    int base_fd;
    int idx;

    vecs[0]  = mkv(288, gm(0) | gm(1), -1, 1, 0, 0, 0, 234);
    vecs[1]  = mkv(288, gm(5), -1, 0, 1, 0, 0, 234);
    vecs[2]  = mkv(288, gm(3) | gm(5), -1, 0, 1, 0, 0, 234);
    vecs[3]  = mkv(287, gm(0) | gm(1), -1, 1, 0, 0, 1, 234);
    vecs[4]  = mkv(290, gm(0) | gm(1), -1, 1, 0, 0, 1, 234);
    vecs[5]  = mkv(288, gm(0) | gm(1), -1, 1, 0, 0, 0, 234);
    vecs[6]  = mkv(288, gm(10) | gm(11), 10, 11, 0, 1, 0, 234);
    vecs[7]  = mkv(288, gm(20) | gm(21), -1, 21, 0, 0, 0, 234);
    vecs[8]  = mkv(0, '0, -1, 0, 1, 0, 1, 0);
    vecs[9]  = mkv(288, gm(52) | gm(53), -1, 0, 1, 0, 0, 234);
    vecs[10] = mkv(288, gm(0) | gm(1) | gm(2), -1, 0, 1, 0, 0, 234);

    // Reset held with live traffic: every output stays at zero.
    rst_n   = 1'b0;
    bus.sdi = '0;
    bus.sdv = 1'b0;
    bus.lat = 1'b0;
    for (int i = 0; i < 4; i++) step(3'($urandom), 1'b1, 1'b0);
    chk("rst_pix_we", int'(bus.pix_we), 0);
    chk("rst_pix_row", int'(bus.pix_row), 0);
    chk("rst_pix_col", int'(bus.pix_col), 0);
    chk("rst_pix_val", int'(bus.pix_val), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk_status("rst", 0, 0, 0, 0);
    step(3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(3'b000, 1'b0, 1'b0);

    // First line after reset doubles as the full pixel-decode check.
    base_we = we_total;
    base_fd = fd_total;
    send_line(0, 288, gm(0) | gm(1), -1);
    close_line("first");
    chk_status("first", 1, 0, 0, 0);
    chk("first_fd_count", fd_total - base_fd, 1);
    chk("pix_we_count", we_total - base_we, 234);
    for (int i = 0; i < 234; i++) begin
      idx = (base_we + i) % 512;
      chk($sformatf("pix%0d_row", i), int'(log_row[idx]), i / 6);
      chk($sformatf("pix%0d_col", i), int'(log_col[idx]), colmap[i % 6]);
      chk($sformatf("pix%0d_val", i), int'(log_val[idx]), i % 8);
    end

    for (int v = 0; v < 11; v++) begin
      base_we = we_total;
      base_fd = fd_total;
      send_line(0, vecs[v].nbits, vecs[v].gmask, vecs[v].bad_k);
      close_line($sformatf("vec%0d", v));
      chk_status($sformatf("vec%0d", v), vecs[v].exp_num, vecs[v].exp_gerr, vecs[v].exp_lane,
                 vecs[v].exp_len);
      chk($sformatf("vec%0d_we_count", v), we_total - base_we, vecs[v].exp_we);
      chk($sformatf("vec%0d_fd_count", v), fd_total - base_fd, 1);
    end

    for (int n = 1; n <= 52; n++) begin
      send_line(0, 288, gm(n - 1) | gm(n), -1);
      close_line($sformatf("sweep%0d", n));
      chk($sformatf("sweep%0d_num", n), int'(bus.grid_num), n);
      chk($sformatf("sweep%0d_err", n), int'(bus.grid_err), 0);
    end

    // Bit on the latch edge: old line closes at 288 bits, bit becomes index 0.
    send_line(0, 288, gm(0) | gm(1), -1);
    base_we = we_total;
    step(3'd5, 1'b1, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    chk("coin_fd_pulse", int'(bus.frame_done), 1);
    step(3'b000, 1'b0, 1'b0);
    chk_status("coin", 1, 0, 0, 0);
    chk("coin_we_count", we_total - base_we, 1);
    chk("coin_row", int'(log_row[base_we % 512]), 0);
    chk("coin_col", int'(log_col[base_we % 512]), 0);
    chk("coin_val", int'(log_val[base_we % 512]), 5);
    send_line(1, 287, gm(0) | gm(1), -1);
    close_line("coin_next");
    chk_status("coin_next", 1, 0, 0, 0);

    // Reset at bit 100 discards the partial line without a FRAME_DONE.
    base_fd = fd_total;
    send_line(0, 100, '0, -1);
    rst_n = 1'b0;
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    chk("midrst_no_fd", fd_total - base_fd, 0);
    chk("midrst_row", int'(bus.pix_row), 0);
    base_we = we_total;
    send_line(0, 288, gm(4) | gm(5), -1);
    close_line("midrst_next");
    chk_status("midrst_next", 5, 0, 0, 0);
    chk("midrst_we_count", we_total - base_we, 234);
    chk("midrst_first_row", int'(log_row[base_we % 512]), 0);
    chk("midrst_first_col", int'(log_col[base_we % 512]), 0);
    chk("midrst_idx7_col", int'(log_col[(base_we + 7) % 512]), 5);
    chk("midrst_idx7_row", int'(log_row[(base_we + 7) % 512]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tspi_rx.md
# tspi_rx

Tri-SPI receiver and frame checker: the receiving end of the three-lane grayscale serial stream that the VFD controller drives into the MN15439A. Deserialises each 288-bit line (39 six-pixel groups plus 54 grid-select bits). Emits one decoded 3-bit pixel write per pixel bit and, on every latch pulse, reports the selected grid pair and protocol errors. Used on-chip as a loopback monitor on the display outputs and in benches as the display model.

## Interface
- No parameters; the frame geometry is fixed: 288 bits per line, 234 pixel bits (39 groups × 6), 54 grid bits, 52 grids.
- CLK  in  1  system clock (12 MHz); all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- SDI  in  3  serial data, lane 0 = S1, lane 1 = S2, lane 2 = S3; one bit per lane per qualified cycle.
- SDV  in  1  bit-valid qualifier; SDI is sampled on cycles with SDV=1 (stands in for the gated SCK).
- LAT  in  1  latch strobe, level; its rising edge closes the current line.
- PIX_WE  out  1  one-cycle pulse: a decoded pixel is presented.
- PIX_ROW  out  6  group index 0–38.
- PIX_COL  out  3  pixel column within group, 0=A … 5=F.
- PIX_VAL  out  3  gray level, {SDI[2],SDI[1],SDI[0]}.
- FRAME_DONE  out  1  one-cycle pulse after each LAT rising edge.
- GRID_NUM  out  6  decoded grid number N (lower of the active pair), 1–52; 0 when invalid.
- GRID_ERR  out  1  grid field is not exactly two adjacent set bits with N in 1–52.
- LANE_ERR  out  1  during the grid field, some bit had lanes not all equal.
- LEN_ERR  out  1  line did not contain exactly 288 qualified bits.

## Operation
- Bit counter BCNT (9 bits) counts qualified bits in the current line, 0–288, and saturates at 288. Bit index = BCNT before the increment.
- Pixel field, index 0–233:
  - Group row = index/6; m = index mod 6.
  - Use a counter pair (row counter plus mod-6 counter), not a divider.
  - Column map by m: 0→A(0), 1→F(5), 2→B(1), 3→E(4), 4→C(2), 5→D(3).
  - Every pixel bit produces PIX_WE.
- Grid field, index 234–287:
  - k = index − 234.
  - The lane-0 value is the grid bit; any lane mismatch sets the sticky lane flag.
  - Track the first set k (FIRST), the count of ones saturating at 3 (ONES), and whether the second one immediately followed the first (ADJ).
- Overrun: any qualified bit with BCNT=288 is ignored (no PIX_WE) and sets the sticky length flag.
- States:
  - IDLE → PIXEL on the first qualified bit.
  - PIXEL → GRID after index 233.
  - GRID → FULL after index 287.
  - Any state → IDLE on a LAT rising edge, which clears BCNT, FIRST, ONES, ADJ and the sticky flags.
- Line close on LAT rising edge (LAT registered; edge = LAT & ~LAT_q):
  - LEN_ERR = (BCNT≠288) | overrun flag.
  - GRID valid iff ONES=2 & ADJ & FIRST≤51; then GRID_NUM = FIRST+1, else GRID_NUM = 0 and GRID_ERR = 1.
  - LANE_ERR = lane flag.
  - Status outputs hold until the next FRAME_DONE.
- Simultaneous LAT edge and SDV:
  - The current line closes without that bit.
  - The bit becomes index 0 of the new line.
- LAT high for multiple cycles closes the line only once.
- A LAT edge on an empty line (BCNT=0) still pulses FRAME_DONE, with LEN_ERR=1 and GRID_ERR=1.

## Timing
- Reset values:
  - PIX_WE=0, PIX_ROW=0, PIX_COL=0, PIX_VAL=0.
  - FRAME_DONE=0, GRID_NUM=0, GRID_ERR=0, LANE_ERR=0, LEN_ERR=0.
  - State IDLE, BCNT=0, LAT_q=0.
- Pixel latency: SDI/SDV sampled at edge t; PIX_WE and PIX_* are registered and valid in the cycle after edge t, high for exactly one cycle.
- Frame latency: LAT first seen high at edge t; FRAME_DONE is high in the cycle after edge t+1, and the status outputs update on that same edge.
- Back-to-back SDV every cycle is supported: 288 bits in 288 cycles, no stall.
- Reset assertion mid-line discards all partial state immediately; no FRAME_DONE is issued.

## Test plan
- Reset: hold RST_N=0 with SDV=1 and random SDI → all outputs 0. Release, then send 288 bits with grid bits at k=0,1 and LAT → FRAME_DONE once, GRID_NUM=1, all error flags 0.
- Pixel decode: send a line where pixel bit i carries SDI=i mod 8 → 234 PIX_WE pulses. Index 7 → ROW=1, COL=5 (F), VAL=7. Index 233 → ROW=38, COL=3 (D), VAL=1.
- Grid sweep: for N=1..52, set grid bits k=N−1 and k=N → GRID_NUM=N, GRID_ERR=0. Single one at k=5 → GRID_ERR=1, GRID_NUM=0. Ones at k=3,5 → GRID_ERR=1.
- Length errors: LAT after 287 bits → LEN_ERR=1. 290 bits → exactly 234 PIX_WE, LEN_ERR=1. The next correct line → LEN_ERR=0.
- Lane mismatch: in the grid field, one bit with SDI=3'b101 → LANE_ERR=1 and the grid is still decoded from lane 0. The pixel field with mixed lanes → no LANE_ERR.
- Corner events: LAT edge coincident with SDV → the closed line reports 288 bits, and the new line starts at ROW=0, COL=0. Reset pulse at bit 100 → no FRAME_DONE, and the next line decodes from index 0.
